// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared burst encodings, master state enum and limits for the AXI-style bridge
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam int   AXI_MAX_SIZE = 4;
  localparam logic BRESP_OKAY   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RESP_CAP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_FINISH
  } axi_state_t;

  // WRAP bursts only make sense for power-of-two beat counts (2 or 4 here).
  function automatic logic burst_legal(input logic [2:0] size, input logic [1:0] btype,
                                       input logic [1:0] len, input int max_size);
    logic ok;
    ok = (int'(size) <= max_size) && (btype != BURST_RSVD);
    if (btype == BURST_WRAP && (len == 2'd0 || len == 2'd2)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/axi_beat_addr_gen.sv
// rtl/axi_beat_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_beat_addr_gen import axi_pkg::*; #(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [1:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] incr;

  always_comb begin
    step      = ADDR_W'(1) << size;
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    incr      = addr + step;
    case (burst)
      BURST_INCR: next_addr = incr;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_master.sv
// rtl/axi_master.sv - single-burst AXI-style initiator; AXI_MASTER_TIMEOUT_EN adds a handshake watchdog
module axi_master import axi_pkg::*; #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 128,
  parameter int MAX_SIZE       = AXI_MAX_SIZE,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_type,
  input  logic [1:0]        cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_data_valid,
  output logic              wr_data_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_beat_addr,
  output logic              rd_data_valid,
  output logic              done,
  output logic              done_err,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [ADDR_W-1:0] out_write_addr,
  output logic [2:0]        Burst_size,
  output logic [1:0]        Burst_type,
  output logic [1:0]        Burst_len,
  output logic              WDVALID,
  input  logic              WDREADY,
  output logic [DATA_W-1:0] out_write_data,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic              BRESP,
  output logic              RAVALID,
  input  logic              RAREADY,
  output logic [ADDR_W-1:0] out_read_addr,
  input  logic              RDVALID,
  output logic              RDREADY,
  input  logic [DATA_W-1:0] out_read_data
);

  axi_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [1:0]        type_q;
  logic [1:0]        len_q;
  logic [1:0]        beat_cnt_q;
  logic [ADDR_W-1:0] beat_addr_q;
  logic [ADDR_W-1:0] beat_addr_nxt;
  logic              wd_valid_q;
  logic              err_q;
  logic              cmd_legal;
  logic              timeout;

  assign cmd_legal      = burst_legal(cmd_size, cmd_type, cmd_len, MAX_SIZE);
  assign out_write_addr = addr_q;
  assign out_read_addr  = addr_q;
  assign Burst_size     = size_q;
  assign Burst_type     = type_q;
  assign Burst_len      = len_q;
  assign WDVALID        = wd_valid_q;

  axi_beat_addr_gen #(.ADDR_W(ADDR_W)) u_beat_addr (
    .addr      (beat_addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (type_q),
    .next_addr (beat_addr_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (cmd_valid) state_nxt = !cmd_legal ? ST_FINISH
                                            : (cmd_write ? ST_WR_ADDR : ST_RD_ADDR);
      ST_WR_ADDR:  if (AWREADY) state_nxt = ST_WR_DATA;
      ST_WR_DATA:  if (wd_valid_q && WDREADY && beat_cnt_q == len_q) state_nxt = ST_WR_RESP;
      ST_WR_RESP:  if (BREADY) state_nxt = ST_RESP_CAP;
      ST_RESP_CAP: state_nxt = ST_FINISH;
      ST_RD_ADDR:  if (RAREADY) state_nxt = ST_RD_DATA;
      ST_RD_DATA:  if (RDVALID && beat_cnt_q == len_q) state_nxt = ST_FINISH;
      ST_FINISH:   state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    if (timeout) state_nxt = ST_FINISH;
  end

  always_comb begin
    cmd_ready     = (state == ST_IDLE);
    AWVALID       = (state == ST_WR_ADDR);
    BVALID        = (state == ST_WR_RESP);
    RAVALID       = (state == ST_RD_ADDR);
    RDREADY       = (state == ST_RD_DATA);
    done          = (state == ST_FINISH);
    done_err      = (state == ST_FINISH) && err_q;
    wr_data_ready = (state == ST_WR_DATA) && !wd_valid_q && wr_data_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q         <= '0;
      size_q         <= '0;
      type_q         <= '0;
      len_q          <= '0;
      beat_cnt_q     <= '0;
      beat_addr_q    <= '0;
      wd_valid_q     <= 1'b0;
      err_q          <= 1'b0;
      out_write_data <= '0;
      rd_data        <= '0;
      rd_beat_addr   <= '0;
      rd_data_valid  <= 1'b0;
    end else begin
      rd_data_valid <= 1'b0;
      if (timeout) begin
        err_q      <= 1'b1;
        wd_valid_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (cmd_valid) begin
            addr_q      <= cmd_addr;
            size_q      <= cmd_size;
            type_q      <= cmd_type;
            len_q       <= cmd_len;
            beat_addr_q <= cmd_addr;
            beat_cnt_q  <= '0;
            wd_valid_q  <= 1'b0;
            err_q       <= !cmd_legal;
          end
          // A held beat blocks loading the next one, so a stalled slave never loses data.
          ST_WR_DATA: begin
            if (wd_valid_q) begin
              if (WDREADY) begin
                wd_valid_q <= 1'b0;
                beat_cnt_q <= beat_cnt_q + 2'd1;
              end
            end else if (wr_data_valid) begin
              out_write_data <= wr_data;
              wd_valid_q     <= 1'b1;
            end
          end
          // The slave registers BRESP on the B handshake edge, so it is valid only now.
          ST_RESP_CAP: err_q <= (BRESP != BRESP_OKAY);
          ST_RD_DATA: if (RDVALID) begin
            rd_data       <= out_read_data;
            rd_beat_addr  <= beat_addr_q;
            rd_data_valid <= 1'b1;
            beat_addr_q   <= beat_addr_nxt;
            beat_cnt_q    <= beat_cnt_q + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt_q;
  logic            waiting;

  assign waiting = (AWVALID && !AWREADY) || (WDVALID && !WDREADY) || (BVALID && !BREADY) ||
                   (RAVALID && !RAREADY) || (RDREADY && !RDVALID);
  assign timeout = waiting && (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   wait_cnt_q <= '0;
    else if (!waiting || timeout) wait_cnt_q <= '0;
    else                         wait_cnt_q <= wait_cnt_q + TO_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

endmodule
